// File: rtl/fir_mc.sv
// ---------------------------------------------------------------------------
// fir_mc : time-multiplexed multi-channel FIR filter.
//
// One multiply-accumulator is shared by all channels. Each calculate strobe
// pushes one new sample into every channel's delay line. The channels are
// then filtered one after another. All channels use a single coefficient set,
// and that set can be rewritten at runtime.
//
// Ports
//   clock        rising-edge clock
//   reset        asynchronous, active-high
//   calculate    start strobe, sampled on the rising edge
//   data_in      packed samples, channel c at [c*WIDTH +: WIDTH]
//   coeff_we     coefficient write enable (accepted only while idle)
//   coeff_addr   tap index to write (ignored when >= TAPS)
//   coeff_data   signed Q1.(COEFF_WIDTH-1) coefficient
//   data_out     rounded and saturated filter output
//   out_channel  channel index belonging to data_out
//   data_good    one-cycle pulse marking data_out/out_channel valid
//   busy         high while a filter sequence is in progress
//   overrun      sticky, set when calculate arrives while busy
// ---------------------------------------------------------------------------
module fir_mc #(
  parameter int WIDTH       = 10,
  parameter int TAPS        = 20,
  parameter int CHANNELS    = 2,
  parameter int COEFF_WIDTH = 10,
  parameter int INIT        = 0
) (
  input  logic                                            clock,
  input  logic                                            reset,
  input  logic                                            calculate,
  input  logic [CHANNELS*WIDTH-1:0]                       data_in,
  input  logic                                            coeff_we,
  input  logic [$clog2(TAPS)-1:0]                         coeff_addr,
  input  logic [COEFF_WIDTH-1:0]                          coeff_data,
  output logic [WIDTH-1:0]                                data_out,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_channel,
  output logic                                            data_good,
  output logic                                            busy,
  output logic                                            overrun
);

  localparam int AW   = $clog2(TAPS);
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW   = WIDTH + COEFF_WIDTH;
  // Sized so that summing TAPS full-scale products can never overflow.
  localparam int ACCW = WIDTH + COEFF_WIDTH + $clog2(TAPS);

  localparam logic [AW-1:0]  LAST_K   = AW'(TAPS - 1);
  localparam logic [AW-1:0]  K_ONE    = AW'(1);
  localparam logic [AW:0]    ADDR_LIM = (AW + 1)'(TAPS);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(CHANNELS - 1);
  localparam logic [CHW-1:0] CH_ONE   = CHW'(1);

  // Half an output LSB, so that the shift rounds half up.
  localparam logic signed [ACCW:0] ROUND_C =
    {{(ACCW + 2 - COEFF_WIDTH){1'b0}}, 1'b1, {(COEFF_WIDTH - 2){1'b0}}};
  localparam logic signed [ACCW:0] SAT_MAX =
    {{(ACCW + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
  localparam logic signed [ACCW:0] SAT_MIN =
    {{(ACCW + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};
  localparam logic signed [COEFF_WIDTH-1:0] IMPULSE_C =
    {1'b0, {(COEFF_WIDTH - 1){1'b1}}};
  localparam logic signed [COEFF_WIDTH-1:0] ZERO_C = {COEFF_WIDTH{1'b0}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic signed [ACCW-1:0]   acc_q, acc_d;
  logic [AW-1:0]            k_q, k_d;
  logic [CHW-1:0]           ch_q, ch_d;
  logic signed [WIDTH-1:0]  dline_q [CHANNELS][TAPS];
  logic signed [WIDTH-1:0]  dline_d [CHANNELS][TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff_q [TAPS];
  logic signed [COEFF_WIDTH-1:0] coeff_d [TAPS];
  logic [WIDTH-1:0]         data_out_q, data_out_d;
  logic [CHW-1:0]           out_channel_q, out_channel_d;
  logic                     data_good_q, data_good_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  logic signed [WIDTH-1:0]       tap_s;
  logic signed [COEFF_WIDTH-1:0] coef_s;
  logic signed [PW-1:0]          prod_s;

  // Round half up, arithmetic shift back to sample scale, then clamp.
  function automatic logic signed [WIDTH-1:0] scale(input logic signed [ACCW-1:0] a);
    logic signed [ACCW:0] sum_s;
    logic signed [ACCW:0] shf_s;
    sum_s = {a[ACCW-1], a} + ROUND_C;
    shf_s = sum_s >>> (COEFF_WIDTH - 1);
    if (shf_s > SAT_MAX) begin
      scale = SAT_MAX[WIDTH-1:0];
    end else if (shf_s < SAT_MIN) begin
      scale = SAT_MIN[WIDTH-1:0];
    end else begin
      scale = shf_s[WIDTH-1:0];
    end
  endfunction

  // Operand select and product for the shared multiplier.
  always_comb begin
    tap_s  = dline_q[ch_q][k_q];
    coef_s = coeff_q[k_q];
    prod_s = tap_s * coef_s;
  end

  // Next-state, datapath and output computation.
  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    k_d           = k_q;
    ch_d          = ch_q;
    dline_d       = dline_q;
    coeff_d       = coeff_q;
    data_out_d    = data_out_q;
    out_channel_d = out_channel_q;
    data_good_d   = 1'b0;
    overrun_d     = overrun_q;

    case (state_q)
      IDLE: begin
        // A write in the same cycle as calculate lands at the start edge
        // and is therefore already used by this run's first MAC.
        if (coeff_we && ({1'b0, coeff_addr} < ADDR_LIM)) begin
          coeff_d[coeff_addr] = coeff_data;
        end else begin
          coeff_d = coeff_q;
        end
        if (calculate) begin
          for (int c = 0; c < CHANNELS; c++) begin
            for (int t = TAPS - 1; t > 0; t--) begin
              dline_d[c][t] = dline_q[c][t-1];
            end
            dline_d[c][0] = data_in[c*WIDTH +: WIDTH];
          end
          acc_d   = {ACCW{1'b0}};
          k_d     = {AW{1'b0}};
          ch_d    = {CHW{1'b0}};
          state_d = MAC;
        end else begin
          state_d = IDLE;
        end
      end
      MAC: begin
        acc_d = acc_q + {{(ACCW - PW){prod_s[PW-1]}}, prod_s};
        if (k_q == LAST_K) begin
          state_d = OUT;
        end else begin
          k_d = k_q + K_ONE;
        end
        if (calculate) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      OUT: begin
        data_out_d    = scale(acc_q);
        out_channel_d = ch_q;
        data_good_d   = 1'b1;
        acc_d         = {ACCW{1'b0}};
        k_d           = {AW{1'b0}};
        if (ch_q == LAST_CH) begin
          ch_d    = {CHW{1'b0}};
          state_d = IDLE;
        end else begin
          ch_d    = ch_q + CH_ONE;
          state_d = MAC;
        end
        if (calculate) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // busy is registered from the next state so it drops on the final OUT edge.
    busy_d = (state_d != IDLE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      acc_q         <= {ACCW{1'b0}};
      k_q           <= {AW{1'b0}};
      ch_q          <= {CHW{1'b0}};
      data_out_q    <= {WIDTH{1'b0}};
      out_channel_q <= {CHW{1'b0}};
      data_good_q   <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
        for (int t = 0; t < TAPS; t++) begin
          dline_q[c][t] <= {WIDTH{1'b0}};
        end
      end
      for (int t = 0; t < TAPS; t++) begin
        coeff_q[t] <= ((INIT == 1) && (t == 0)) ? IMPULSE_C : ZERO_C;
      end
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      k_q           <= k_d;
      ch_q          <= ch_d;
      data_out_q    <= data_out_d;
      out_channel_q <= out_channel_d;
      data_good_q   <= data_good_d;
      busy_q        <= busy_d;
      overrun_q     <= overrun_d;
      dline_q       <= dline_d;
      coeff_q       <= coeff_d;
    end
  end

  assign data_out    = data_out_q;
  assign out_channel = out_channel_q;
  assign data_good   = data_good_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_fir_mc.sv
// ---------------------------------------------------------------------------
// tb_fir_mc : directed self-checking bench for fir_mc.
// WIDTH=10, TAPS=20, CHANNELS=2, COEFF_WIDTH=10, INIT=1 (impulse at tap 0).
// Expected values are hand-computed with the filter's round/saturate rule.
// ---------------------------------------------------------------------------
module tb_fir_mc;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        calculate = 1'b0;
  logic [19:0] data_in = 20'd0;
  logic        coeff_we = 1'b0;
  logic [4:0]  coeff_addr = 5'd0;
  logic [9:0]  coeff_data = 10'd0;
  logic [9:0]  data_out;
  logic [0:0]  out_channel;
  logic        data_good;
  logic        busy;
  logic        overrun;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int in0;
    int in1;
    int exp0;
    int exp1;
  } vec_t;

  vec_t vecs [25];
  int   ramp [21];

  fir_mc #(
    .WIDTH(10), .TAPS(20), .CHANNELS(2), .COEFF_WIDTH(10), .INIT(1)
  ) dut (
    .clock(clock), .reset(reset), .calculate(calculate), .data_in(data_in),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr), .coeff_data(coeff_data),
    .data_out(data_out), .out_channel(out_channel), .data_good(data_good),
    .busy(busy), .overrun(overrun)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int dout();
    return int'($signed(data_out));
  endfunction

  task automatic set_in(input int a, input int b);
    data_in = {10'(b), 10'(a)};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    calculate = 1'b0;
    coeff_we = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic write_coeff(input int a, input int d);
    @(negedge clock);
    coeff_we = 1'b1;
    coeff_addr = 5'(a);
    coeff_data = 10'(d);
    @(negedge clock);
    coeff_we = 1'b0;
  endtask

  // Wait (bounded) for a data_good pulse, sampled on negedges.
  task automatic wait_good(input string name);
    int n;
    n = 0;
    while (data_good !== 1'b1 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check({name, "_timeout"}, (n < 200) ? 1 : 0, 1);
  endtask

  task automatic collect(input string name, input int exp0, input int exp1);
    wait_good(name);
    check({name, "_ch0_data"}, dout(), exp0);
    check({name, "_ch0_idx"}, int'(out_channel), 0);
    @(negedge clock);
    wait_good(name);
    check({name, "_ch1_data"}, dout(), exp1);
    check({name, "_ch1_idx"}, int'(out_channel), 1);
    @(negedge clock);
  endtask

  task automatic run_calc(input string name, input int a, input int b,
                          input int exp0, input int exp1);
    @(negedge clock);
    set_in(a, b);
    calculate = 1'b1;
    @(negedge clock);
    calculate = 1'b0;
    collect(name, exp0, exp1);
  endtask

  initial begin
    int ng;

    // Coefficients all 26, ch0 held at 200: floor((5200*n + 256) / 512).
    ramp = '{10, 20, 30, 41, 51, 61, 71, 81, 91, 102, 112, 122, 132, 142,
             152, 163, 173, 183, 193, 203, 203};
    for (int i = 0; i < 21; i++) vecs[i] = '{200, 0, ramp[i], 0};
    // c0=c1=511: 511 -> 510, 511 -> sat 511, -512 -> -1, -512 -> sat -512.
    vecs[21] = '{511, 0, 510, 0};
    vecs[22] = '{511, 0, 511, 0};
    vecs[23] = '{-512, 0, -1, 0};
    vecs[24] = '{-512, 0, -512, 0};

    // Reset state and exact timing of one impulse-coefficient run.
    do_reset();
    check("rst_data_out", dout(), 0);
    check("rst_out_channel", int'(out_channel), 0);
    check("rst_data_good", int'(data_good), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_overrun", int'(overrun), 0);

    @(negedge clock);
    set_in(200, -100);
    calculate = 1'b1;
    @(posedge clock);                  // E0
    @(negedge clock);
    calculate = 1'b0;
    check("t1_busy_after_e0", int'(busy), 1);
    repeat (20) @(posedge clock);      // E1..E20
    @(negedge clock);
    check("t1_no_good_e20", int'(data_good), 0);
    @(posedge clock);                  // E21
    @(negedge clock);
    check("t1_good_e21", int'(data_good), 1);
    check("t1_ch0_data", dout(), 200);
    check("t1_ch0_idx", int'(out_channel), 0);
    check("t1_busy_e21", int'(busy), 1);
    repeat (20) @(posedge clock);      // E22..E41
    @(negedge clock);
    check("t1_no_good_e41", int'(data_good), 0);
    @(posedge clock);                  // E42
    @(negedge clock);
    check("t1_good_e42", int'(data_good), 1);
    check("t1_ch1_data", dout(), -100);
    check("t1_ch1_idx", int'(out_channel), 1);
    check("t1_busy_e42", int'(busy), 0);
    @(negedge clock);
    check("t1_good_pulse_end", int'(data_good), 0);

    // Table-driven runs: ramp/settle and saturation.
    for (int i = 0; i < 25; i++) begin
      if (i == 0) begin
        do_reset();
        for (int t = 0; t < 20; t++) write_coeff(t, 26);
      end else if (i == 21) begin
        do_reset();
        write_coeff(1, 511);
      end
      run_calc($sformatf("vec%0d", i), vecs[i].in0, vecs[i].in1,
               vecs[i].exp0, vecs[i].exp1);
    end

    // Calculate during a run: overrun, no shift, and busy coefficient write ignored.
    do_reset();
    @(negedge clock);
    set_in(200, -100);
    calculate = 1'b1;
    @(posedge clock);                  // E0
    @(negedge clock);
    calculate = 1'b0;
    repeat (4) @(posedge clock);       // E1..E4
    @(negedge clock);
    set_in(77, 50);
    calculate = 1'b1;
    coeff_we = 1'b1;
    coeff_addr = 5'd0;
    coeff_data = 10'd0;
    @(posedge clock);                  // E5
    @(negedge clock);
    calculate = 1'b0;
    coeff_we = 1'b0;
    check("t4_overrun_set", int'(overrun), 1);
    collect("t4_run", 200, -100);
    run_calc("t4_next", 200, -100, 200, -100);
    check("t4_overrun_sticky", int'(overrun), 1);

    // Reset at E10 of a run: immediate clear, then no data_good.
    @(negedge clock);
    set_in(200, -100);
    calculate = 1'b1;
    @(posedge clock);                  // E0
    @(negedge clock);
    calculate = 1'b0;
    repeat (10) @(posedge clock);      // E10
    #1 reset = 1'b1;
    #1;
    check("t5_data_out", dout(), 0);
    check("t5_out_channel", int'(out_channel), 0);
    check("t5_busy", int'(busy), 0);
    check("t5_overrun", int'(overrun), 0);
    check("t5_data_good", int'(data_good), 0);
    @(negedge clock);
    reset = 1'b0;
    ng = 0;
    repeat (50) begin
      @(negedge clock);
      if (data_good === 1'b1) ng++;
    end
    check("t5_no_good_after_reset", ng, 0);
    run_calc("t5_rerun", 200, -100, 200, -100);

    // Out-of-range coefficient address is ignored.
    do_reset();
    write_coeff(25, 0);
    write_coeff(20, 0);
    run_calc("t6_run", 200, -100, 200, -100);

    // Coefficient write in the start cycle is used by that run (c0 = 0.5).
    do_reset();
    @(negedge clock);
    set_in(200, -100);
    calculate = 1'b1;
    coeff_we = 1'b1;
    coeff_addr = 5'd0;
    coeff_data = 10'd256;
    @(negedge clock);
    calculate = 1'b0;
    coeff_we = 1'b0;
    collect("t7_coincident", 100, -50);

    // Calculate held high restarts on the edge after the last data_good.
    do_reset();
    @(negedge clock);
    set_in(200, -100);
    calculate = 1'b1;
    ng = 0;
    while (!(data_good === 1'b1 && out_channel == 1'b1) && ng < 200) begin
      @(negedge clock);
      ng++;
    end
    check("t8_first_run_timeout", (ng < 200) ? 1 : 0, 1);
    check("t8_busy_last_good", int'(busy), 0);
    check("t8_last_data", dout(), -100);
    @(negedge clock);
    check("t8_restart_busy", int'(busy), 1);
    check("t8_overrun", int'(overrun), 1);
    calculate = 1'b0;
    collect("t8_second_run", 200, -100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
